// File: rtl/fft_r2_stage_controller_pkg.sv
// fft_r2_stage_controller_pkg: shared widths, FSM states and bit-reverse helper
package fft_r2_stage_controller_pkg;
  localparam int UNIFIED_W = 24;
  localparam int BF_OUT_W = 16;
  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_r2_stage_controller_if.sv
// fft_r2_stage_controller_if: sample in/out streams and butterfly operand/result bus
interface fft_r2_stage_controller_if #(parameter int LOG2N = 4);
  import fft_r2_stage_controller_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [UNIFIED_W-1:0] in_data;
  logic bf_valid;
  logic [UNIFIED_W-1:0] bf_a;
  logic [UNIFIED_W-1:0] bf_b;
  logic [LOG2N-2:0] bf_tw_idx;
  logic [BF_OUT_W-1:0] bf_x;
  logic [BF_OUT_W-1:0] bf_y;
  logic out_valid;
  logic out_ready;
  logic [UNIFIED_W-1:0] out_data;
  logic done;
  modport master (
    input in_valid, in_data, bf_x, bf_y, out_ready,
    output in_ready, bf_valid, bf_a, bf_b, bf_tw_idx, out_valid, out_data, done
  );
  modport slave (
    output in_valid, in_data, bf_x, bf_y, out_ready,
    input in_ready, bf_valid, bf_a, bf_b, bf_tw_idx, out_valid, out_data, done
  );
endinterface

// File: rtl/fft_r2_addr_gen.sv
// fft_r2_addr_gen: stage/pair counters producing DIT butterfly addresses and twiddle index
module fft_r2_addr_gen #(
  parameter int LOG2N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [LOG2N-1:0] idx_a,
  output logic [LOG2N-1:0] idx_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             last_pair
);
  logic [LOG2N-1:0] s, kk, half, pos;
  logic [LOG2N-2:0] k;
  always_comb begin
    kk = LOG2N'(k);
    half = LOG2N'(1) << s;
    pos = kk & (half - LOG2N'(1));
    idx_a = ((kk >> s) << (s + LOG2N'(1))) | pos;
    idx_b = idx_a | half;
    tw_idx = (LOG2N-1)'(pos << (LOG2N'(LOG2N - 1) - s));
    last_pair = (s == LOG2N'(LOG2N - 1)) && (&k);
  end
  // counters wrap to stage 0 after the final pair, ready for the next transform
  always_ff @(posedge clk)
    if (!rst_n) begin
      s <= '0;
      k <= '0;
    end else if (en) begin
      k <= k + (LOG2N-1)'(1);
      s <= last_pair ? '0 : s + LOG2N'(&k);
    end
endmodule

// File: rtl/fft_r2_stage_controller.sv
// fft_r2_stage_controller: radix-2 DIT FFT sequencer with in-place buffer; FFT_CYCLE_COUNT_EN adds cycle_count
module fft_r2_stage_controller #(
  parameter int N_POINTS = 16,
  parameter int LOG2N = 4,
  parameter int ADD_PRECISION = 0
) (
  input logic clk,
  input logic rst_n,
`ifdef FFT_CYCLE_COUNT_EN
  output logic [15:0] cycle_count,
`endif
  fft_r2_stage_controller_if.master io
);
  import fft_r2_stage_controller_pkg::*;
  state_t state;
  logic [UNIFIED_W-1:0] mem [N_POINTS];
  logic [UNIFIED_W-1:0] wb_x, wb_y;
  logic [LOG2N-1:0] c, u, ia, ib;
  logic last_pair, in_hs, out_hs;
  fft_r2_addr_gen #(.LOG2N(LOG2N)) u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .en(io.bf_valid),
    .idx_a(ia),
    .idx_b(ib),
    .tw_idx(io.bf_tw_idx),
    .last_pair(last_pair)
  );
  assign in_hs = io.in_valid && io.in_ready;
  assign out_hs = io.out_valid && io.out_ready;
  assign wb_x = (ADD_PRECISION != 0) ? {io.bf_x, 8'h00} : {16'h0000, io.bf_x[7:0]};
  assign wb_y = (ADD_PRECISION != 0) ? {io.bf_y, 8'h00} : {16'h0000, io.bf_y[7:0]};
  assign io.bf_a = mem[ia];
  assign io.bf_b = mem[ib];
  assign io.out_data = io.out_valid ? mem[u] : '0;
  assign io.done = out_hs && (u == LOG2N'(N_POINTS - 1));
  // butterfly results land in the same cycle they are read, so stages never overlap stale data
  always_ff @(posedge clk)
    if (rst_n && in_hs) mem[LOG2N'(bitrev(32'(c), LOG2N))] <= io.in_data;
    else if (rst_n && io.bf_valid) begin
      mem[ia] <= wb_x;
      mem[ib] <= wb_y;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ST_LOAD;
      c <= '0;
      u <= '0;
      io.in_ready <= 1'b0;
      io.bf_valid <= 1'b0;
      io.out_valid <= 1'b0;
    end else
      case (state)
        ST_LOAD: begin
          io.in_ready <= 1'b1;
          if (in_hs) begin
            c <= c + LOG2N'(1);
            if (c == LOG2N'(N_POINTS - 1)) begin
              state <= ST_COMPUTE;
              io.in_ready <= 1'b0;
              io.bf_valid <= 1'b1;
            end
          end
        end
        ST_COMPUTE:
          if (last_pair) begin
            state <= ST_UNLOAD;
            io.bf_valid <= 1'b0;
            io.out_valid <= 1'b1;
          end
        default:
          if (out_hs) begin
            u <= u + LOG2N'(1);
            if (io.done) begin
              state <= ST_LOAD;
              io.out_valid <= 1'b0;
              io.in_ready <= 1'b1;
            end
          end
      endcase
`ifdef FFT_CYCLE_COUNT_EN
  logic run;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cycle_count <= '0;
      run <= 1'b0;
    end else if (in_hs && c == '0) begin
      cycle_count <= 16'd1;
      run <= 1'b1;
    end else if (run) begin
      cycle_count <= cycle_count + 16'd1;
      run <= !io.done;
    end
`endif
endmodule

// File: tb/tb_fft_r2_stage_controller.sv
// tb_fft_r2_stage_controller: directed checks of load, address sweep, unload, reset and back-to-back frames
module tb_fft_r2_stage_controller;
  import fft_r2_stage_controller_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [23:0] m [16];
  fft_r2_stage_controller_if #(.LOG2N(4)) io ();
`ifdef FFT_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif
  fft_r2_stage_controller #(.N_POINTS(16), .LOG2N(4), .ADD_PRECISION(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FFT_CYCLE_COUNT_EN
    .cycle_count(cycle_count),
`endif
    .io(io)
  );
  assign io.bf_x = io.bf_a[23:8];
  assign io.bf_y = io.bf_b[23:8];
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction
  function automatic logic [23:0] sample(input int mode, input int i);
    logic [7:0] b;
    b = 8'(i);
    if (mode == 0) return {8'h00, b, 8'h00};
    if (mode == 1) return {8'(i * 7 + 3), 8'hFF - b, 8'hA5};
    return {b ^ 8'h5A, 8'(i * 13), 8'h3C};
  endfunction
  task automatic load_frame(input int mode, input bit hold);
    for (int i = 0; i < 16; i++) begin
      io.in_valid = 1'b1;
      io.in_data = sample(mode, i);
      m[rev4(4'(i))] = sample(mode, i);
      @(posedge clk); #1;
    end
    if (hold) io.in_data = 24'hFFFFFF;
    else io.in_valid = 1'b0;
    check("in_ready_after_load", 32'(io.in_ready), 32'd0);
    check("bf_valid_after_load", 32'(io.bf_valid), 32'd1);
  endtask
  task automatic compute_frame(input bit spot);
    int cyc;
    int s, k, half, p, ia, ib;
    logic [23:0] a, b;
    cyc = 0;
    while (io.bf_valid && cyc < 40) begin
      s = cyc / 8;
      k = cyc % 8;
      half = 1 << s;
      p = k % half;
      ia = (k / half) * 2 * half + p;
      ib = ia + half;
      a = m[ia];
      b = m[ib];
      check("bf_a", 32'(io.bf_a), 32'(a));
      check("bf_b", 32'(io.bf_b), 32'(b));
      check("bf_tw_idx", 32'(io.bf_tw_idx), 32'(p * (8 / half)));
      if (spot && cyc == 0) begin
        check("c0_idx_a", 32'(dut.u_addr.idx_a), 32'd0);
        check("c0_idx_b", 32'(dut.u_addr.idx_b), 32'd1);
        check("c0_tw", 32'(io.bf_tw_idx), 32'd0);
      end
      if (spot && cyc == 9) begin
        check("s1k1_idx_a", 32'(dut.u_addr.idx_a), 32'd1);
        check("s1k1_idx_b", 32'(dut.u_addr.idx_b), 32'd3);
        check("s1k1_tw", 32'(io.bf_tw_idx), 32'd4);
      end
      if (spot && cyc == 31) begin
        check("s3k7_idx_a", 32'(dut.u_addr.idx_a), 32'd7);
        check("s3k7_idx_b", 32'(dut.u_addr.idx_b), 32'd15);
        check("s3k7_tw", 32'(io.bf_tw_idx), 32'd7);
      end
      m[ia] = {a[23:8], 8'h00};
      m[ib] = {b[23:8], 8'h00};
      @(posedge clk); #1;
      cyc++;
    end
    check("compute_cycles", 32'(cyc), 32'd32);
  endtask
  task automatic unload_frame(input bit toggle);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int hs, dones;
    hs = 0;
    dones = 0;
    for (int cyc = 0; cyc < 64 && hs < 16; cyc++) begin
      io.out_ready = toggle ? pat[cyc % 4] : 1'b1;
      #1;
      check("out_valid", 32'(io.out_valid), 32'd1);
      check("out_data", 32'(io.out_data), 32'(m[hs]));
      check("done", 32'(io.done), 32'(io.out_ready && hs == 15));
      if (io.done) dones++;
      if (io.out_ready) hs++;
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    check("handshakes", 32'(hs), 32'd16);
    check("done_pulses", 32'(dones), 32'd1);
    check("in_ready_after_done", 32'(io.in_ready), 32'd1);
    check("out_valid_after_done", 32'(io.out_valid), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(io.in_ready), 32'd0);
    check("rst_bf_valid", 32'(io.bf_valid), 32'd0);
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_done", 32'(io.done), 32'd0);
    check("rst_out_data", 32'(io.out_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(io.in_ready), 32'd1);
    load_frame(0, 1'b0);
    check("buf8", 32'(dut.mem[8]), 32'h000100);
    compute_frame(1'b1);
    unload_frame(1'b1);
    load_frame(1, 1'b1);
    compute_frame(1'b0);
    unload_frame(1'b0);
`ifdef FFT_CYCLE_COUNT_EN
    check("cycle_count", 32'(cycle_count), 32'd64);
    repeat (3) @(posedge clk);
    #1;
    check("cycle_count_hold", 32'(cycle_count), 32'd64);
`endif
    load_frame(2, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_bf_valid", 32'(io.bf_valid), 32'd0);
    check("midrst_in_ready", 32'(io.in_ready), 32'd0);
    check("midrst_out_data", 32'(io.out_data), 32'd0);
`ifdef FFT_CYCLE_COUNT_EN
    check("midrst_cycle_count", 32'(cycle_count), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", 32'(dut.state), 32'(ST_LOAD));
    check("post_rst_in_ready", 32'(io.in_ready), 32'd1);
    check("post_rst_bf_valid", 32'(io.bf_valid), 32'd0);
    check("post_rst_out_valid", 32'(io.out_valid), 32'd0);
    load_frame(2, 1'b0);
    compute_frame(1'b1);
    unload_frame(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
